// File: rtl/fx_bus_pkg.sv
// fx_bus_pkg: shared types and helpers for the fx register bus controller.
//   fx_state_e   - controller FSM states (IDLE, ACCESS, DONE)
//   FX_ERR_FILL  - all-ones pattern returned on fx_q for an error completion
//   fx_idx_width - width of the slave index field taken from the top address bits
package fx_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } fx_state_e;

  // Wide enough for any supported data width; users slice the low DW bits.
  localparam logic [63:0] FX_ERR_FILL = {64{1'b1}};

  // A single slave still needs one index bit so an index of 1 reads as unmapped.
  function automatic int fx_idx_width(input int nslv);
    if (nslv <= 1) begin
      return 1;
    end else begin
      return $clog2(nslv);
    end
  endfunction

endpackage

// File: rtl/fx_bus_if.sv
// fx_bus_if: master-side handshake of the fx register bus.
//   fx_req/fx_wr/fx_addr/fx_data - request from the control master
//   fx_q/fx_ack/fx_err/fx_busy   - completion and status back to the master
// The master modport is the requester's view; the slave modport is the controller's view.
interface fx_bus_if #(
  parameter int DW = 8,
  parameter int AW = 8
);

  logic          fx_req;
  logic          fx_wr;
  logic [AW-1:0] fx_addr;
  logic [DW-1:0] fx_data;
  logic [DW-1:0] fx_q;
  logic          fx_ack;
  logic          fx_err;
  logic          fx_busy;

  modport master (
    output fx_req, fx_wr, fx_addr, fx_data,
    input  fx_q, fx_ack, fx_err, fx_busy
  );

  modport slave (
    input  fx_req, fx_wr, fx_addr, fx_data,
    output fx_q, fx_ack, fx_err, fx_busy
  );

endinterface

// File: rtl/fx_bus_tmo.sv
// fx_bus_tmo: access timeout counter.
//   clk_sys - system clock
//   rst     - synchronous active-high reset
//   clr     - force count to zero (held while not accessing a slave)
//   en      - advance count by one
//   expired - count has reached TMO-1, i.e. this is the last allowed access cycle
module fx_bus_tmo #(
  parameter int TMO = 15
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TMO);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Next count: clear has priority over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CW'(TMO - 1));

endmodule

// File: rtl/fx_bus_ctl.sv
// fx_bus_ctl: registered single-master / NSLV-slave transaction controller.
//   clk_sys, rst - clock and synchronous active-high reset
//   bus          - master handshake (fx_req/wr/addr/data in; fx_q/ack/err/busy out)
//   slv_req      - one-hot request to the addressed slave
//   slv_wr/slv_addr/slv_data - latched transaction fields, stable while accessing
//   slv_q/slv_ack - per-slave read data (slave i at [i*DW +: DW]) and acknowledge
// The slave index is the top SW address bits. Every output is a flop, so there is
// no combinational path from slv_q or slv_ack to the master side.
module fx_bus_ctl
  import fx_bus_pkg::*;
#(
  parameter int NSLV = 4,
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int TMO  = 15,
  localparam int SW  = fx_idx_width(NSLV)
) (
  input  logic               clk_sys,
  input  logic               rst,
  fx_bus_if.slave            bus,
  output logic [NSLV-1:0]    slv_req,
  output logic               slv_wr,
  output logic [AW-SW-1:0]   slv_addr,
  output logic [DW-1:0]      slv_data,
  input  logic [NSLV*DW-1:0] slv_q,
  input  logic [NSLV-1:0]    slv_ack
);

  fx_state_e        state_d, state_q;
  logic [SW-1:0]    idx_d, idx_q;
  logic             wr_d, wr_q;
  logic [AW-SW-1:0] addr_d, addr_q;
  logic [DW-1:0]    data_d, data_q;
  logic [DW-1:0]    q_d, q_q;
  logic             ack_d, ack_q;
  logic             err_d, err_q;
  logic             busy_d, busy_q;
  logic [NSLV-1:0]  req_d, req_q;

  logic [SW-1:0]    idx_in;
  logic             mapped;
  logic             sel_ack;
  logic [DW-1:0]    sel_q;
  logic             tmo_clr, tmo_en, tmo_exp;

  assign idx_in = bus.fx_addr[AW-1 -: SW];
  // Extra bit so NSLV itself is representable when NSLV is a power of two.
  assign mapped = ({1'b0, idx_in} < (SW+1)'(NSLV));

  fx_bus_tmo #(.TMO(TMO)) u_tmo (
    .clk_sys (clk_sys),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_exp)
  );

  // Pick the latched slave's acknowledge and read data; other slaves are masked out.
  always_comb begin
    sel_ack = 1'b0;
    sel_q   = {DW{1'b0}};
    for (int i = 0; i < NSLV; i++) begin
      sel_ack = sel_ack | (slv_ack[i] & (idx_q == SW'(i)));
      sel_q   = sel_q | (slv_q[i*DW +: DW] & {DW{idx_q == SW'(i)}});
    end
  end

  // Transaction sequencing and next values of every registered output.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    q_d     = q_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tmo_clr = 1'b1;
    tmo_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fx_req) begin
          idx_d  = idx_in;
          wr_d   = bus.fx_wr;
          addr_d = bus.fx_addr[AW-SW-1:0];
          data_d = bus.fx_data;
          if (mapped) begin
            state_d = ACCESS;
          end else begin
            state_d = DONE;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            q_d     = FX_ERR_FILL[DW-1:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        tmo_clr = 1'b0;
        // An acknowledge on the final allowed cycle still counts as success.
        if (sel_ack) begin
          state_d = DONE;
          ack_d   = 1'b1;
          q_d     = wr_q ? q_q : sel_q;
        end else if (tmo_exp) begin
          state_d = DONE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          q_d     = FX_ERR_FILL[DW-1:0];
        end else begin
          tmo_en  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    req_d  = {NSLV{1'b0}};
    for (int i = 0; i < NSLV; i++) begin
      req_d[i] = (state_d == ACCESS) & (idx_d == SW'(i));
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= {SW{1'b0}};
      wr_q    <= 1'b0;
      addr_q  <= {(AW-SW){1'b0}};
      data_q  <= {DW{1'b0}};
      q_q     <= {DW{1'b0}};
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= {NSLV{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      q_q     <= q_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
    end
  end

  assign bus.fx_q    = q_q;
  assign bus.fx_ack  = ack_q;
  assign bus.fx_err  = err_q;
  assign bus.fx_busy = busy_q;
  assign slv_req     = req_q;
  assign slv_wr      = wr_q;
  assign slv_addr    = addr_q;
  assign slv_data    = data_q;

endmodule
